// File: rtl/uart_tx_queue_if.sv
// Host/transmitter-facing signal bundle for uart_tx_queue.
// master = host + transmitter side, slave = the queue itself.
interface uart_tx_queue_if #(
  parameter int ADDR_W = 4
);
  logic              wr_en;
  logic [7:0]        wr_data;
  logic              full;
  logic              empty;
  logic [ADDR_W:0]   count;
  logic              tx_start;
  logic [7:0]        tx_data;
  logic              tx_busy;
  logic              start_err;

  modport master (
    output wr_en, wr_data, tx_busy,
    input  full, empty, count, tx_start, tx_data, start_err
  );

  modport slave (
    input  wr_en, wr_data, tx_busy,
    output full, empty, count, tx_start, tx_data, start_err
  );
endinterface

// File: rtl/uart_tx_queue.sv
// Byte FIFO plus start sequencer feeding a UART transmitter via tx_start/tx_busy.
// Optional UART_TXQ_FLUSH_EN adds a flush input that empties the queue.
//
// state   | meaning
// S_IDLE  | waiting for a queued byte and an idle transmitter
// S_LOAD  | popped byte settling on tx_data
// S_START | tx_start asserted, waiting for tx_busy or timeout
// S_WAIT  | frame in progress, waiting for tx_busy to fall
module uart_tx_queue #(
  parameter int DEPTH         = 16,
  parameter int ADDR_W        = 4,
  parameter int START_TIMEOUT = 15
) (
  input  logic clock,
  input  logic reset,
`ifdef UART_TXQ_FLUSH_EN
  input  logic flush,
`endif
  uart_tx_queue_if.slave bus
);

  localparam int TO_W = $clog2(START_TIMEOUT + 1);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_START, S_WAIT} state_t;

  state_t              state_q, state_d;
  logic [TO_W-1:0]     cnt_q, cnt_d;
  logic [ADDR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]     count_q, count_d;
  logic                full_q, full_d;
  logic                empty_q, empty_d;
  logic                tx_start_q, tx_start_d;
  logic [7:0]          tx_data_q, tx_data_d;
  logic                start_err_q, start_err_d;
  logic [7:0]          mem_q [DEPTH];
  logic                pop;
  logic                wr_accept;
  logic                flush_req;

`ifdef UART_TXQ_FLUSH_EN
  assign flush_req = flush;
`else
  assign flush_req = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    tx_start_d  = 1'b0;
    tx_data_d   = tx_data_q;
    start_err_d = start_err_q;
    pop         = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!empty_q && !bus.tx_busy) begin
          pop       = 1'b1;
          tx_data_d = mem_q[rd_ptr_q];
          state_d   = S_LOAD;
        end
      end
      S_LOAD: begin
        cnt_d   = '0;
        state_d = S_START;
      end
      S_START: begin
        // tx_start is registered, so it lags the state by one cycle and
        // stays high exactly while the counter walks 0..START_TIMEOUT-1.
        if (bus.tx_busy) begin
          state_d = S_WAIT;
        end else if (cnt_q == TO_W'(START_TIMEOUT)) begin
          state_d     = S_IDLE;
          start_err_d = 1'b1;
        end else begin
          cnt_d      = cnt_q + TO_W'(1);
          tx_start_d = 1'b1;
        end
      end
      S_WAIT: begin
        if (!bus.tx_busy) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    wr_accept = bus.wr_en && (!full_q || pop) && !flush_req;
    wr_ptr_d  = wr_accept ? wr_ptr_q + ADDR_W'(1) : wr_ptr_q;
    rd_ptr_d  = pop ? rd_ptr_q + ADDR_W'(1) : rd_ptr_q;
    count_d   = count_q;
    case ({wr_accept, pop})
      2'b10:   count_d = count_q + (ADDR_W+1)'(1);
      2'b01:   count_d = count_q - (ADDR_W+1)'(1);
      default: count_d = count_q;
    endcase
    if (flush_req) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end
    full_d  = (count_d == (ADDR_W+1)'(DEPTH));
    empty_d = (count_d == '0);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      full_q      <= 1'b0;
      empty_q     <= 1'b1;
      tx_start_q  <= 1'b0;
      tx_data_q   <= 8'h00;
      start_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      full_q      <= full_d;
      empty_q     <= empty_d;
      tx_start_q  <= tx_start_d;
      tx_data_q   <= tx_data_d;
      start_err_q <= start_err_d;
    end
  end

  // Storage needs no reset; occupancy is tracked by the pointers.
  always_ff @(posedge clock) begin
    if (!reset && wr_accept) mem_q[wr_ptr_q] <= bus.wr_data;
  end

  assign bus.full      = full_q;
  assign bus.empty     = empty_q;
  assign bus.count     = count_q;
  assign bus.tx_start  = tx_start_q;
  assign bus.tx_data   = tx_data_q;
  assign bus.start_err = start_err_q;

endmodule

// File: tb/tb_uart_tx_queue.sv
// Directed testbench for uart_tx_queue with a hand-driven transmitter busy model.
// Optional flush checks are compiled only with UART_TXQ_FLUSH_EN.
module tb_uart_tx_queue;
  localparam int DEPTH  = 16;
  localparam int ADDR_W = 4;

  logic clock = 1'b0;
  logic reset;
`ifdef UART_TXQ_FLUSH_EN
  logic flush;
`endif

  always #5 clock = ~clock;

  uart_tx_queue_if #(.ADDR_W(ADDR_W)) bus ();

  uart_tx_queue #(
    .DEPTH(DEPTH),
    .ADDR_W(ADDR_W),
    .START_TIMEOUT(15)
  ) dut (
    .clock(clock),
    .reset(reset),
`ifdef UART_TXQ_FLUSH_EN
    .flush(flush),
`endif
    .bus(bus)
  );

  int vectors     = 0;
  int miscompares = 0;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic push(input logic [7:0] d);
    bus.wr_en   = 1'b1;
    bus.wr_data = d;
    tick();
    bus.wr_en   = 1'b0;
  endtask

  task automatic wait_start(input string tag);
    int n;
    n = 0;
    while (bus.tx_start !== 1'b1 && n < 200) begin
      tick();
      n++;
    end
    chk({tag, "_start"}, {31'd0, bus.tx_start}, 32'd1);
  endtask

  // Transmitter model: raise busy on seeing tx_start, hold 10 cycles, release.
  task automatic send_frame(input string tag, input logic [7:0] exp);
    wait_start(tag);
    chk({tag, "_data"}, {24'd0, bus.tx_data}, {24'd0, exp});
    bus.tx_busy = 1'b1;
    tick();
    chk({tag, "_drop"}, {31'd0, bus.tx_start}, 32'd0);
    repeat (9) tick();
    bus.tx_busy = 1'b0;
    tick();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    bus.wr_en   = 1'b0;
    bus.wr_data = 8'h00;
    bus.tx_busy = 1'b0;
`ifdef UART_TXQ_FLUSH_EN
    flush = 1'b0;
`endif
    do_reset();

    // Reset state
    chk("rst_count", {27'd0, bus.count}, 32'd0);
    chk("rst_empty", {31'd0, bus.empty}, 32'd1);
    chk("rst_full", {31'd0, bus.full}, 32'd0);
    chk("rst_start", {31'd0, bus.tx_start}, 32'd0);
    chk("rst_data", {24'd0, bus.tx_data}, 32'h00);
    chk("rst_err", {31'd0, bus.start_err}, 32'd0);

    // Single byte latency: write edge N, tx_start after N+3
    push(8'hA5);
    chk("a5_count_n", {27'd0, bus.count}, 32'd1);
    chk("a5_empty_n", {31'd0, bus.empty}, 32'd0);
    tick();
    chk("a5_count_n1", {27'd0, bus.count}, 32'd0);
    chk("a5_start_n1", {31'd0, bus.tx_start}, 32'd0);
    tick();
    chk("a5_start_n2", {31'd0, bus.tx_start}, 32'd0);
    tick();
    chk("a5_start_n3", {31'd0, bus.tx_start}, 32'd1);
    chk("a5_data_n3", {24'd0, bus.tx_data}, 32'hA5);
    bus.tx_busy = 1'b1;
    tick();
    chk("a5_start_off", {31'd0, bus.tx_start}, 32'd0);
    repeat (9) tick();
    bus.tx_busy = 1'b0;
    tick();
    chk("a5_empty_end", {31'd0, bus.empty}, 32'd1);

    // Three queued bytes, each frame waits for busy to fall
    push(8'h11);
    push(8'h22);
    push(8'h33);
    send_frame("f11", 8'h11);
    tick();
    tick();
    chk("b2b_no_early_start", {31'd0, bus.tx_start}, 32'd0);
    send_frame("f22", 8'h22);
    send_frame("f33", 8'h33);
    n = 0;
    repeat (20) begin
      tick();
      if (bus.tx_start === 1'b1) n++;
    end
    chk("f3_extra_starts", n, 32'd0);
    chk("f3_count", {27'd0, bus.count}, 32'd0);

    // 17 pushes with busy held high: 17th dropped
    bus.tx_busy = 1'b1;
    do_reset();
    for (int j = 1; j <= 17; j++) push(8'h40 + 8'(j));
    chk("ovf_full", {31'd0, bus.full}, 32'd1);
    chk("ovf_count", {27'd0, bus.count}, 32'd16);
    chk("ovf_start", {31'd0, bus.tx_start}, 32'd0);
    bus.tx_busy = 1'b0;
    for (int j = 1; j <= 16; j++) send_frame($sformatf("ovf%0d", j), 8'h40 + 8'(j));
    n = 0;
    repeat (20) begin
      tick();
      if (bus.tx_start === 1'b1) n++;
    end
    chk("ovf_17th_sent", n, 32'd0);
    chk("ovf_count_end", {27'd0, bus.count}, 32'd0);

    // Write accepted while full because a pop happens the same cycle
    bus.tx_busy = 1'b1;
    do_reset();
    for (int j = 0; j < 16; j++) push(8'h80 + 8'(j));
    chk("fp_full", {31'd0, bus.full}, 32'd1);
    bus.tx_busy = 1'b0;
    bus.wr_en   = 1'b1;
    bus.wr_data = 8'hC3;
    tick();
    bus.wr_en   = 1'b0;
    chk("fp_count", {27'd0, bus.count}, 32'd16);
    chk("fp_full_after", {31'd0, bus.full}, 32'd1);
    for (int j = 0; j < 16; j++) send_frame($sformatf("fp%0d", j), 8'h80 + 8'(j));
    send_frame("fp_c3", 8'hC3);
    chk("fp_empty_end", {31'd0, bus.empty}, 32'd1);

    // Start timeout: tx_busy never rises
    do_reset();
    push(8'h5A);
    wait_start("to");
    n = 0;
    while (bus.tx_start === 1'b1 && n < 100) begin
      n++;
      tick();
    end
    chk("to_high_cycles", n, 32'd15);
    chk("to_err", {31'd0, bus.start_err}, 32'd1);
    chk("to_count", {27'd0, bus.count}, 32'd0);
    chk("to_data_hold", {24'd0, bus.tx_data}, 32'h5A);
    // Back in IDLE: a new byte follows the normal 3-cycle latency
    push(8'h77);
    tick();
    tick();
    chk("to_idle_n2", {31'd0, bus.tx_start}, 32'd0);
    tick();
    chk("to_idle_n3", {31'd0, bus.tx_start}, 32'd1);
    chk("to_idle_data", {24'd0, bus.tx_data}, 32'h77);
    bus.tx_busy = 1'b1;
    tick();
    bus.tx_busy = 1'b0;
    tick();
    chk("to_err_sticky", {31'd0, bus.start_err}, 32'd1);

    // Reset during WAIT with five bytes queued
    for (int j = 0; j < 6; j++) push(8'hD0 + 8'(j));
    wait_start("rw");
    bus.tx_busy = 1'b1;
    tick();
    chk("rw_count_pre", {27'd0, bus.count}, 32'd5);
    chk("rw_start_pre", {31'd0, bus.tx_start}, 32'd0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rw_start", {31'd0, bus.tx_start}, 32'd0);
    chk("rw_data", {24'd0, bus.tx_data}, 32'h00);
    chk("rw_count", {27'd0, bus.count}, 32'd0);
    chk("rw_empty", {31'd0, bus.empty}, 32'd1);
    chk("rw_err", {31'd0, bus.start_err}, 32'd0);
    bus.tx_busy = 1'b0;
    repeat (5) tick();
    chk("rw_no_start", {31'd0, bus.tx_start}, 32'd0);

`ifdef UART_TXQ_FLUSH_EN
    // Flush beats a simultaneous write
    bus.tx_busy = 1'b1;
    push(8'hE1);
    push(8'hE2);
    push(8'hE3);
    flush       = 1'b1;
    bus.wr_en   = 1'b1;
    bus.wr_data = 8'hEE;
    tick();
    flush     = 1'b0;
    bus.wr_en = 1'b0;
    chk("fl_count", {27'd0, bus.count}, 32'd0);
    chk("fl_empty", {31'd0, bus.empty}, 32'd1);
    bus.tx_busy = 1'b0;
    repeat (6) tick();
    chk("fl_no_start", {31'd0, bus.tx_start}, 32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
